teclado_matriz: RTL and testbench



---
 rtl/teclado_matriz_pkg.sv | 64 ++++++
 rtl/teclado_debounce.sv | 31 +++
 rtl/teclado_matriz.sv | 133 +++++++++++++
 tb/tb_teclado_matriz.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/teclado_matriz_pkg.sv
// Shared types and key map for the 4x4 keypad scanner.
// State encoding, 4-bit key codes and the (row, column) -> code lookup.
package teclado_matriz_pkg;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_e;

  localparam logic [3:0] KEY_0    = 4'h0;
  localparam logic [3:0] KEY_1    = 4'h1;
  localparam logic [3:0] KEY_2    = 4'h2;
  localparam logic [3:0] KEY_3    = 4'h3;
  localparam logic [3:0] KEY_4    = 4'h4;
  localparam logic [3:0] KEY_5    = 4'h5;
  localparam logic [3:0] KEY_6    = 4'h6;
  localparam logic [3:0] KEY_7    = 4'h7;
  localparam logic [3:0] KEY_8    = 4'h8;
  localparam logic [3:0] KEY_9    = 4'h9;
  localparam logic [3:0] KEY_A    = 4'hA;
  localparam logic [3:0] KEY_B    = 4'hB;
  localparam logic [3:0] KEY_C    = 4'hC;
  localparam logic [3:0] KEY_D    = 4'hD;
  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;

  function automatic logic [3:0] key_code(input logic [1:0] row_idx,
                                          input logic [1:0] col_idx);
    logic [3:0] code;
    case ({row_idx, col_idx})
      4'b00_00: code = KEY_1;
      4'b00_01: code = KEY_2;
      4'b00_10: code = KEY_3;
      4'b00_11: code = KEY_A;
      4'b01_00: code = KEY_4;
      4'b01_01: code = KEY_5;
      4'b01_10: code = KEY_6;
      4'b01_11: code = KEY_B;
      4'b10_00: code = KEY_7;
      4'b10_01: code = KEY_8;
      4'b10_10: code = KEY_9;
      4'b10_11: code = KEY_C;
      4'b11_00: code = KEY_STAR;
      4'b11_01: code = KEY_0;
      4'b11_10: code = KEY_HASH;
      4'b11_11: code = KEY_D;
      default:  code = KEY_0;
    endcase
    return code;
  endfunction

  // Several rows at once: the lowest-index row is the one reported.
  function automatic logic [1:0] lowest_row(input logic [3:0] rows);
    logic [1:0] idx;
    if (rows[0])      idx = 2'd0;
    else if (rows[1]) idx = 2'd1;
    else if (rows[2]) idx = 2'd2;
    else              idx = 2'd3;
    return idx;
  endfunction

endpackage

// File: rtl/teclado_debounce.sv
// Stable-count debouncer shared by the press and release phases.
// done_o is high once match_i has held for DEBOUNCE_CYCLES consecutive cycles.
module teclado_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic match_i,
  output logic done_o
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || !match_i) cnt_d = '0;
    else if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign done_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/teclado_matriz.sv
// 4x4 matrix keypad scanner: rotating column drive, debounced press/release, key_valid strobe.
// Define TECLADO_SYNC_EN to add a 2-flop synchronizer on the row inputs.
module teclado_matriz
  import teclado_matriz_pkg::*;
#(
  parameter int unsigned SCAN_CYCLES     = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] entrada_teclado,
  output logic [3:0] saida_conf_teclado,
  output logic [3:0] bcd_out,
  output logic       key_valid,
  output state_e     state_dbg_o
);

  localparam int unsigned SW = $clog2(SCAN_CYCLES);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYCLES - 1);

  logic [3:0] rs;

`ifdef TECLADO_SYNC_EN
  logic [3:0] sync1_q, sync2_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= entrada_teclado;
      sync2_q <= sync1_q;
    end
  end
  assign rs = sync2_q;
`else
  assign rs = entrada_teclado;
`endif

  state_e        state_q, state_d;
  logic [1:0]    col_q, col_d;
  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic [3:0]    cap_q, cap_d;
  logic [3:0]    bcd_q, bcd_d;
  logic          valid_q, valid_d;
  logic          dbc_clear, dbc_match, dbc_done;

  teclado_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .clk_i   (clk),
    .rst_i   (rst),
    .clear_i (dbc_clear),
    .match_i (dbc_match),
    .done_o  (dbc_done)
  );

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    scan_cnt_d = scan_cnt_q;
    cap_d      = cap_q;
    bcd_d      = bcd_q;
    valid_d    = 1'b0;
    dbc_clear  = 1'b0;
    dbc_match  = 1'b0;
    case (state_q)
      ST_SCAN: begin
        dbc_clear = 1'b1;
        // Detection wins over a same-cycle advance, so the pre-advance column is captured.
        if (rs != 4'b0) begin
          cap_d      = rs;
          scan_cnt_d = '0;
          state_d    = ST_DEBOUNCE;
        end else if (scan_cnt_q == SCAN_LAST) begin
          scan_cnt_d = '0;
          col_d      = col_q + 2'd1;
        end else begin
          scan_cnt_d = scan_cnt_q + 1'b1;
        end
      end
      ST_DEBOUNCE: begin
        dbc_match = (rs == cap_q);
        if (rs != cap_q) begin
          col_d      = col_q + 2'd1;
          scan_cnt_d = '0;
          state_d    = ST_SCAN;
        end else if (dbc_done) begin
          bcd_d   = key_code(lowest_row(cap_q), col_q);
          valid_d = 1'b1;
          state_d = ST_HELD;
        end
      end
      ST_HELD: begin
        dbc_clear = 1'b1;
        if (rs == 4'b0) state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        dbc_match = (rs == 4'b0);
        if (rs != 4'b0) begin
          state_d = ST_HELD;
        end else if (dbc_done) begin
          col_d      = col_q + 2'd1;
          scan_cnt_d = '0;
          state_d    = ST_SCAN;
        end
      end
      default: state_d = ST_SCAN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_SCAN;
      col_q      <= 2'd0;
      scan_cnt_q <= '0;
      cap_q      <= 4'b0;
      bcd_q      <= KEY_0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      scan_cnt_q <= scan_cnt_d;
      cap_q      <= cap_d;
      bcd_q      <= bcd_d;
      valid_q    <= valid_d;
    end
  end

  // Decoded straight from a 2-bit register, so the drive is one-hot in every state.
  assign saida_conf_teclado = 4'b0001 << col_q;
  assign bcd_out            = bcd_q;
  assign key_valid          = valid_q;
  assign state_dbg_o        = state_q;

endmodule

// File: tb/tb_teclado_matriz.sv
// Directed bench for teclado_matriz: keypad model driven by the column outputs plus a row override.
// Expected key codes are queued per press and matched on every key_valid strobe.
module tb_teclado_matriz;
  import teclado_matriz_pkg::*;

  localparam int SC = 4;
  localparam int DC = 3;
`ifdef TECLADO_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] entrada;
  logic [3:0] saida;
  logic [3:0] bcd;
  logic       kv;
  state_e     state_dbg;

  logic [3:0] press_cols = 4'b0;
  logic [3:0] press_rows = 4'b0;
  logic       ovr_en = 1'b0;
  logic [3:0] ovr_rows = 4'b0;

  // A pressed key connects its row to its column only while that column is driven.
  assign entrada = ovr_en ? ovr_rows : (((saida & press_cols) != 4'b0) ? press_rows : 4'b0);

  teclado_matriz #(.SCAN_CYCLES(SC), .DEBOUNCE_CYCLES(DC)) dut (
    .clk                (clk),
    .rst                (rst),
    .entrada_teclado    (entrada),
    .saida_conf_teclado (saida),
    .bcd_out            (bcd),
    .key_valid          (kv),
    .state_dbg_o        (state_dbg)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int pulses   = 0;
  logic [3:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Scoreboard: every strobe must consume one queued expected code.
  always @(negedge clk) begin
    if (kv === 1'b1) begin
      pulses++;
      check("valid_pending", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) check("valid_code", bcd, exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_col_start(input logic [3:0] mask);
    logic [3:0] prev;
    logic found;
    prev  = saida;
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      tick();
      if (saida == mask && prev != mask) found = 1'b1;
      prev = saida;
    end
    check("col_wait", found, 1);
  endtask

  task automatic wait_valid(input int max_cycles, output int n);
    n = 0;
    for (int i = 0; i < max_cycles; i++) begin
      tick();
      n++;
      if (kv) break;
    end
    check("valid_wait", kv, 1);
  endtask

  task automatic release_key(input logic [3:0] col_m);
    press_rows = 4'b0;
    repeat (DC + 1 + SYNC_LAT) tick();
    check("release_frozen", saida, col_m);
    tick();
    check("release_resume", saida, {col_m[2:0], col_m[3]});
  endtask

  task automatic press_key(input logic [3:0] col_m, input logic [3:0] rows_m,
                           input logic [3:0] code);
    int n;
    press_cols = col_m;
    press_rows = rows_m;
    exp_q.push_back(code);
    wait_valid(80, n);
    check("key_bcd", bcd, code);
    tick();
    check("pulse_width", kv, 0);
    repeat (6) tick();
    check("held_frozen", saida, col_m);
    release_key(col_m);
  endtask

  typedef struct {
    logic [3:0] col;
    logic [3:0] rows;
    logic [3:0] code;
  } key_vec_t;

  key_vec_t keys[8];

  initial begin
    int n;
    int p0;

    keys[0] = '{4'b0001, 4'b0011, 4'h1};  // two rows: row 0 wins
    keys[1] = '{4'b1000, 4'b1000, 4'hD};
    keys[2] = '{4'b0010, 4'b1000, 4'h0};
    keys[3] = '{4'b1000, 4'b0001, 4'hA};
    keys[4] = '{4'b0001, 4'b1000, 4'hE};
    keys[5] = '{4'b0001, 4'b0100, 4'h7};
    keys[6] = '{4'b0100, 4'b0100, 4'h9};
    keys[7] = '{4'b1000, 4'b0100, 4'hC};

    // Reset values and idle rotation.
    rst = 1'b0;
    #2 rst = 1'b1;
    #2;
    check("rst_col", saida, 4'b0001);
    check("rst_bcd", bcd, 4'h0);
    check("rst_valid", kv, 0);
    check("rst_state", state_dbg, ST_SCAN);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k <= 16; k++) begin
      check("rotation", saida, 4'b0001 << ((k / SC) % 4));
      tick();
    end

    // Press "5": latency from detection, code, single strobe, frozen drive.
    wait_col_start(4'b0001);
    press_cols = 4'b0010;
    press_rows = 4'b0010;
    exp_q.push_back(4'h5);
    p0 = pulses;
    wait_col_start(4'b0010);
    wait_valid(40, n);
    check("latency_5", n - 1, DC + 1 + SYNC_LAT);
    check("bcd_5", bcd, 4'h5);
    repeat (10) tick();
    check("frozen_5", saida, 4'b0010);
    check("pulses_5", pulses - p0, 1);
    release_key(4'b0010);

    // Bounce: two cycles of row 0 then nothing.
    ovr_en = 1'b1;
    ovr_rows = 4'b0;
    wait_col_start(4'b0001);
    p0 = pulses;
    ovr_rows = 4'b0001;
    tick();
    tick();
    ovr_rows = 4'b0;
    repeat (1 + SYNC_LAT) tick();
    check("bounce_resume", saida, 4'b0010);
    repeat (8) tick();
    check("bounce_no_valid", pulses - p0, 0);
    ovr_en = 1'b0;

    // Hold "#" for 50 cycles with a one-cycle dropout.
    p0 = pulses;
    press_cols = 4'b0100;
    press_rows = 4'b1000;
    exp_q.push_back(4'hF);
    wait_valid(80, n);
    repeat (20) tick();
    press_rows = 4'b0;
    tick();
    press_rows = 4'b1000;
    repeat (29) tick();
    check("hold_bcd", bcd, 4'hF);
    check("hold_frozen", saida, 4'b0100);
    check("hold_pulses", pulses - p0, 1);
    release_key(4'b0100);

    foreach (keys[i]) press_key(keys[i].col, keys[i].rows, keys[i].code);

    // Reset two cycles after detection: asynchronous clear, no strobe.
    p0 = pulses;
    press_cols = 4'b0010;
    press_rows = 4'b0010;
    wait_col_start(4'b0010);
    repeat (3 + SYNC_LAT) tick();
    check("mid_state", state_dbg, ST_DEBOUNCE);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_col", saida, 4'b0001);
    check("mid_rst_bcd", bcd, 4'h0);
    check("mid_rst_valid", kv, 0);
    check("mid_rst_state", state_dbg, ST_SCAN);
    press_rows = 4'b0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (12) tick();
    check("mid_rst_no_pulse", pulses - p0, 0);

    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
